// File: rtl/seg_pkg.sv
// Shared widths and types for the 8-digit 7-segment scan controller.
package seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;
    localparam int SEL_W      = 3;

    typedef logic [DIGIT_W-1:0] digit_t;
    typedef digit_t digit_arr_t [NUM_DIGITS];

    // Digit index increment; wraps 7 -> 0 through the natural SEL_W overflow.
    function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] s);
        return s + SEL_W'(1);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Upstream-facing bundle of the scan controller: register-file writes,
// scan/blank controls, and the registered digit outputs.
interface seg_scan_ctrl_if;
    import seg_pkg::*;

    logic                  scan_en;
    logic                  wr_en;
    logic [SEL_W-1:0]      wr_addr;
    digit_t                wr_data;
    logic [NUM_DIGITS-1:0] digit_en;
    digit_t                num;
    logic [SEL_W-1:0]      sel;
    logic                  blank;
    logic                  tick;

    modport master (
        output scan_en, wr_en, wr_addr, wr_data, digit_en,
        input  num, sel, blank, tick
    );

    modport slave (
        input  scan_en, wr_en, wr_addr, wr_data, digit_en,
        output num, sel, blank, tick
    );

endinterface

// File: rtl/seg_prescaler.sv
// Dwell prescaler: counts 0..CLK_DIV-1 while enabled and pulses tc
// combinationally during the terminal-count cycle.
module seg_prescaler #(
    parameter int CLK_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tc    = en && (cnt_q == CNT_W'(CLK_DIV - 1));
        cnt_d = cnt_q;
        if (tc) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexing scan controller for an 8-digit common-anode display:
// digit register file, select counter and registered decoder outputs.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int CLK_DIV = 100000
) (
    input  logic            clk,
    input  logic            reset,
    seg_scan_ctrl_if.slave  bus
);

    logic             tc;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;
    digit_arr_t       regs_q;
    digit_arr_t       regs_d;
    digit_t           num_q;
    digit_t           num_d;
    logic             blank_q;
    logic             blank_d;
    logic             tick_q;
    logic             tick_d;

    seg_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (bus.scan_en),
        .tc    (tc)
    );

    // Outputs look at the select value being loaded this edge, and a write
    // landing on that digit is bypassed so the stale value is never shown.
    always_comb begin
        sel_d  = tc ? sel_inc(sel_q) : sel_q;
        regs_d = regs_q;
        if (bus.wr_en) begin
            regs_d[bus.wr_addr] = bus.wr_data;
        end
        num_d   = (bus.wr_en && (bus.wr_addr == sel_d)) ? bus.wr_data : regs_q[sel_d];
        blank_d = ~bus.digit_en[sel_d];
        tick_d  = tc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q   <= '0;
            regs_q  <= '{default: '0};
            num_q   <= '0;
            blank_q <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            regs_q  <= regs_d;
            num_q   <= num_d;
            blank_q <= blank_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.sel   = sel_q;
    assign bus.num   = num_q;
    assign bus.blank = blank_q;
    assign bus.tick  = tick_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexing scan controller for the board's 8-digit common-anode 7-segment display.
- Holds eight 4-bit digit values in a register file, written by upstream logic.
- Steps a 3-bit digit select through 0..7 at a prescaled rate, presenting the selected digit value and select on registered outputs to the downstream hex-to-segment decoder and anode decoder.
- Provides per-digit blanking so the top level can force all anodes high (off) for disabled digits.

Parameters:
- CLK_DIV, 100000, clk cycles per digit dwell (100 MHz gives 1 kHz per digit, 125 Hz full refresh); legal range >= 2.
- CNT_W, $clog2(CLK_DIV), prescaler width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- scan_en  in  1  1 = scan runs; 0 = prescaler and select freeze.
- wr_en  in  1  write strobe for digit register file.
- wr_addr  in  3  digit index to write (0 = rightmost digit).
- wr_data  in  4  hex value to store.
- digit_en  in  8  per-digit enable mask; bit i = 0 blanks digit i.
- num  out  4  value of currently selected digit, to segment decoder.
- sel  out  3  currently selected digit index, to anode decoder.
- blank  out  1  1 = current digit disabled; top level drives all anodes high.
- tick  out  1  one-cycle pulse on every digit advance.

Behaviour:
- Clock and reset: one clock domain, clk. reset is asynchronous and active-high.
- Reset values: prescaler = 0, sel = 0, all eight digit registers = 4'h0, num = 4'h0, tick = 0, blank = ~digit_en[0] sampled on first clock after reset release; blank = 1 while reset is asserted.
- Prescaler:
  - When scan_en = 1, counts 0..CLK_DIV-1 and wraps to 0.
  - Terminal count (CLK_DIV-1) with scan_en = 1: next cycle sel <= sel+1, wrapping 7 -> 0, and tick = 1 for exactly that cycle.
  - When scan_en = 0, prescaler and sel hold their values and tick = 0; resumes from the held count when scan_en returns to 1.
- Digit register file:
  - wr_en = 1 at a rising edge writes wr_data into reg[wr_addr].
  - Writes are accepted every cycle, independent of scan_en.
  - No handshake and no back-pressure.
- Outputs num, sel, blank, tick are all registered:
  - sel_next = sel+1 on terminal count, else sel.
  - num <= (wr_en && wr_addr == sel_next) ? wr_data : reg[sel_next] (write-through bypass).
  - blank <= ~digit_en[sel_next].
- Latency:
  - Write to the displayed digit appears on num 1 cycle after the write edge.
  - A digit_en change appears on blank 1 cycle later.
- Simultaneous advance and write to the newly selected digit: num shows wr_data on the advance cycle, never the stale value.
- Reset mid-scan: all state clears immediately (asynchronous), including stored digits. The scan restarts at sel = 0 with a full CLK_DIV dwell after release.
- No glitch requirement on num/sel beyond being registered. The dwell of every digit is exactly CLK_DIV cycles while scan_en = 1.

Decomposition:
- Shared package seg_pkg:
  - NUM_DIGITS = 8
  - DIGIT_W = 4
  - SEL_W = 3
  - typedef logic [DIGIT_W-1:0] digit_t
  - typedef digit_t digit_arr_t [NUM_DIGITS]
- One natural sub-module: seg_prescaler (parameterised CLK_DIV, inputs en/clk/reset, output one-cycle terminal-count pulse).
- Register file, select counter and output registers stay in seg_scan_ctrl.

Test Plan (CLK_DIV = 4 for simulation):
- Reset then scan_en = 1, digit_en = 8'hFF, no writes:
  - sel steps 0,1,...,7,0 with exactly 4 cycles per value.
  - tick pulses once per step.
  - num = 0 and blank = 0 throughout.
- Write reg[i] = i+8 for i = 0..7, then scan:
  - num tracks sel as 8,9,A,B,C,D,E,F.
- While sel = 3, write wr_addr = 3, wr_data = 4'h5:
  - num = 5 on the next cycle.
  - Write on the advance edge to wr_addr = 4, data 4'hC: num = C in the same cycle sel becomes 4.
- digit_en = 8'b1010_1010:
  - blank = 1 on sel = 0,2,4,6 and 0 on sel = 1,3,5,7.
- Deassert scan_en for 10 cycles mid-dwell at count 2:
  - sel holds and tick stays 0.
  - After re-enable, the advance occurs after exactly 2 more cycles.
- Assert reset asynchronously (between clock edges) at sel = 6 with data loaded:
  - sel, num and tick go to 0 and blank goes to 1 immediately.
  - After release, all digits read 0.
